// File: rtl/vga_sync_decoder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vga_sync_decoder_if
// Brief    : VGA sync/blank inputs and recovered timing outputs of the decoder.
// Revision : 1.0
// ============================================================================
interface vga_sync_decoder_if;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic [9:0] PixX;
    logic [9:0] PixY;
    logic       Pixel_valid;
    logic       Locked;
    logic [9:0] H_Meas;
    logic [9:0] V_Meas;
    logic       Sync_Err;
    logic       Blank_Err;

    modport master (
        output VGA_HS, VGA_VS, VGA_BLANK_N,
        input  PixX, PixY, Pixel_valid, Locked, H_Meas, V_Meas, Sync_Err, Blank_Err
    );

    modport slave (
        input  VGA_HS, VGA_VS, VGA_BLANK_N,
        output PixX, PixY, Pixel_valid, Locked, H_Meas, V_Meas, Sync_Err, Blank_Err
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vga_sync_decoder
// Brief    : Recovers pixel position from VGA sync, measures line/frame periods
//            and tracks lock against the nominal timing.
// Revision : 1.0
// ============================================================================
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_SYNC_START = 656,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input wire                Clk,
    input wire                Reset,
    vga_sync_decoder_if.slave vga
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_TOTAL    = 10'(H_TOTAL);
    localparam logic [9:0] C_V_TOTAL    = 10'(V_TOTAL);
    localparam logic [9:0] C_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0] C_H_SYNC     = 10'(H_SYNC_START);
    localparam logic [9:0] C_V_SYNC     = 10'(V_SYNC_START);
    localparam logic [9:0] C_SAT        = 10'd1023;
    localparam logic [9:0] C_SAT_M1     = 10'd1022;
    localparam logic [2:0] C_LOCK_FRAMES = 3'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic [9:0] h_pred_q, h_pred_d, v_pred_q, v_pred_d;
    logic [9:0] hp_cnt_q, hp_cnt_d;
    logic       hp_valid_q, hp_valid_d;
    logic [9:0] line_cnt_q, line_cnt_d;
    logic       line_err_seen_q, line_err_seen_d;
    logic [2:0] good_frames_q, good_frames_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [9:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic       pixel_valid_q, pixel_valid_d;
    logic       sync_err_q, sync_err_d;
    logic       blank_err_q, blank_err_d;

    logic       hs_fall, vs_fall, line_err, frame_ok, locked, active_exp;
    logic [9:0] pos_h, pos_v, line_cnt_inc;

    // Position recovery, period measurement and frame judgement
    always_comb begin
        hs_d    = vga.VGA_HS;
        vs_d    = vga.VGA_VS;
        hs_fall = hs_q & ~vga.VGA_HS;
        vs_fall = vs_q & ~vga.VGA_VS;

        pos_h = hs_fall ? C_H_SYNC : h_pred_q;
        pos_v = vs_fall ? C_V_SYNC : v_pred_q;
        if (pos_h == C_H_LAST) begin
            h_pred_d = '0;
            v_pred_d = (pos_v == C_V_LAST) ? '0 : pos_v + 10'd1;
        end else begin
            h_pred_d = pos_h + 10'd1;
            v_pred_d = pos_v;
        end
        pix_x_d = pos_h;
        pix_y_d = pos_v;

        hp_cnt_d   = (hp_cnt_q == C_SAT) ? hp_cnt_q : hp_cnt_q + 10'd1;
        hp_valid_d = hp_valid_q;
        h_meas_d   = h_meas_q;
        line_err   = 1'b0;
        if (hs_fall) begin
            if (hp_valid_q) begin
                h_meas_d = hp_cnt_q;
                line_err = (hp_cnt_q != C_H_TOTAL);
            end
            hp_cnt_d   = 10'd1;
            hp_valid_d = 1'b1;
        end else if (hp_valid_q && hp_cnt_q == C_SAT_M1) begin
            // Flags HS loss exactly once, as the counter steps onto saturation
            line_err = 1'b1;
        end

        line_cnt_inc = (hs_fall && line_cnt_q != C_SAT) ? line_cnt_q + 10'd1 : line_cnt_q;
        line_cnt_d      = line_cnt_inc;
        v_meas_d        = v_meas_q;
        line_err_seen_d = line_err_seen_q | line_err;
        frame_ok        = 1'b0;
        if (vs_fall) begin
            v_meas_d        = line_cnt_inc;
            line_cnt_d      = '0;
            line_err_seen_d = 1'b0;
            frame_ok        = (line_cnt_inc == C_V_TOTAL) && !line_err_seen_q && !line_err;
        end
    end

    // Lock state machine
    always_comb begin
        state_d       = state_q;
        good_frames_d = good_frames_q;
        sync_err_d    = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                // The frame in progress is partial, so it is never judged
                if (vs_fall) begin
                    state_d       = ST_ACQUIRE;
                    good_frames_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (vs_fall) begin
                    if (frame_ok) begin
                        good_frames_d = good_frames_q + 3'd1;
                        if (good_frames_q + 3'd1 >= C_LOCK_FRAMES) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_frames_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_err || (vs_fall && !frame_ok)) begin
                    state_d       = ST_UNLOCKED;
                    good_frames_d = '0;
                    sync_err_d    = 1'b1;
                end
            end
            default: begin
                state_d       = ST_UNLOCKED;
                good_frames_d = '0;
            end
        endcase

        locked        = (state_q == ST_LOCKED);
        active_exp    = (pos_h < C_H_ACTIVE) && (pos_v < C_V_ACTIVE);
        blank_err_d   = locked && (vga.VGA_BLANK_N != active_exp);
        pixel_valid_d = vga.VGA_BLANK_N & locked;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= ST_UNLOCKED;
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
            h_pred_q        <= '0;
            v_pred_q        <= '0;
            hp_cnt_q        <= '0;
            hp_valid_q      <= 1'b0;
            line_cnt_q      <= '0;
            line_err_seen_q <= 1'b0;
            good_frames_q   <= '0;
            pix_x_q         <= '0;
            pix_y_q         <= '0;
            h_meas_q        <= '0;
            v_meas_q        <= '0;
            pixel_valid_q   <= 1'b0;
            sync_err_q      <= 1'b0;
            blank_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            hs_q            <= hs_d;
            vs_q            <= vs_d;
            h_pred_q        <= h_pred_d;
            v_pred_q        <= v_pred_d;
            hp_cnt_q        <= hp_cnt_d;
            hp_valid_q      <= hp_valid_d;
            line_cnt_q      <= line_cnt_d;
            line_err_seen_q <= line_err_seen_d;
            good_frames_q   <= good_frames_d;
            pix_x_q         <= pix_x_d;
            pix_y_q         <= pix_y_d;
            h_meas_q        <= h_meas_d;
            v_meas_q        <= v_meas_d;
            pixel_valid_q   <= pixel_valid_d;
            sync_err_q      <= sync_err_d;
            blank_err_q     <= blank_err_d;
        end
    end

    assign vga.PixX        = pix_x_q;
    assign vga.PixY        = pix_y_q;
    assign vga.Pixel_valid = pixel_valid_q;
    assign vga.Locked      = locked;
    assign vga.H_Meas      = h_meas_q;
    assign vga.V_Meas      = v_meas_q;
    assign vga.Sync_Err    = sync_err_q;
    assign vga.Blank_Err   = blank_err_q;

endmodule
`default_nettype wire
